layer_store: RTL and testbench

Output stage directly downstream of the layers block. Accepts each finished result vector (DEPTH_NB pixels of IMG_WIDTH bits) over the result valid/ready handshake and serializes it into MEM_DWIDTH-bit words. Writes those words to the output image buffer at consecutive addresses. Job base address and vector count are programmed over the shared cfg bus; `done` pulses when the programmed number of vectors has been written.

---
 rtl/layer_store.sv | 145 ++++++++++++++
 tb/tb_layer_store.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_store.sv
// layer_store: serializes finished result vectors from the layers block
// into MEM_DWIDTH-bit words written to the output image buffer.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cfg_data/addr/valid       shared cfg bus (base address, vector count)
//   result_bus/val/rdy        result vector handshake from layers
//   wr_addr/data/val/rdy      word write port to the image buffer
//   busy, done                job in progress, one-cycle completion pulse

module layer_store #(
   parameter int CFG_DWIDTH = 32,
   parameter int CFG_AWIDTH = 5,
   parameter int DEPTH_NB   = 16,
   parameter int IMG_WIDTH  = 16,
   parameter int MEM_DWIDTH = 64,
   parameter int MEM_AWIDTH = 16,
   // register map shared with the cfg_parameters.vh address table
   parameter logic [CFG_AWIDTH-1:0] CFG_STR_ADDR = 5'd12,
   parameter logic [CFG_AWIDTH-1:0] CFG_STR_CNT  = 5'd13
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [CFG_DWIDTH-1:0]         cfg_data,
   input  logic [CFG_AWIDTH-1:0]         cfg_addr,
   input  logic                          cfg_valid,
   input  logic [DEPTH_NB*IMG_WIDTH-1:0] result_bus,
   input  logic                          result_val,
   output logic                          result_rdy,
   output logic [MEM_AWIDTH-1:0]         wr_addr,
   output logic [MEM_DWIDTH-1:0]         wr_data,
   output logic                          wr_val,
   input  logic                          wr_rdy,
   output logic                          busy,
   output logic                          done
);

   localparam int VW     = DEPTH_NB * IMG_WIDTH;
   localparam int CHUNKS = VW / MEM_DWIDTH;
   localparam int IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

   typedef enum logic [3:0] {
      IDLE  = 4'b0001,
      LOAD  = 4'b0010,
      WRITE = 4'b0100,
      DONE  = 4'b1000
   } state_t;

   state_t state, state_nx;

   logic [MEM_AWIDTH-1:0] base_reg;
   logic [MEM_AWIDTH-1:0] ptr;
   logic [15:0]           rem;
   logic [VW-1:0]         hold;
   logic [IW-1:0]         idx;

   logic cnt_wr;
   logic arm;
   logic take;
   logic acc;
   logic last_chunk;

   // upper cfg bits carry nothing for this block
   logic unused_cfg;
   assign unused_cfg = ^cfg_data[CFG_DWIDTH-1:16];

   assign cnt_wr     = cfg_valid && (cfg_addr == CFG_STR_CNT);
   assign arm        = cnt_wr && (state == IDLE) && (|cfg_data[15:0]);
   assign take       = result_val && (state == LOAD);
   assign acc        = wr_rdy && (state == WRITE);
   assign last_chunk = (idx == IW'(CHUNKS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (1'b1)
         state[0]: begin
            if (arm) state_nx = LOAD;
         end
         state[1]: begin
            if (take) state_nx = WRITE;
         end
         state[2]: begin
            if (acc && last_chunk) begin
               state_nx = (rem == 16'd1) ? DONE : LOAD;
            end
         end
         state[3]: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // base register survives reset; it only feeds the next arm
   always_ff @(posedge clk) begin
      if (cfg_valid && (cfg_addr == CFG_STR_ADDR)) begin
         base_reg <= cfg_data[MEM_AWIDTH-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr  <= '0;
         rem  <= '0;
         hold <= '0;
         idx  <= '0;
      end else begin
         if (arm) begin
            ptr <= base_reg;
            rem <= cfg_data[15:0];
         end
         if (take) begin
            hold <= result_bus;
            idx  <= '0;
         end
         if (acc) begin
            ptr <= ptr + MEM_AWIDTH'(1);
            if (last_chunk) begin
               idx <= '0;
               rem <= rem - 16'd1;
            end else begin
               idx <= idx + IW'(1);
            end
         end
      end
   end

   assign result_rdy = (state == LOAD);
   assign wr_val     = (state == WRITE);
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);
   assign wr_addr    = ptr;
   assign wr_data    = hold[idx*MEM_DWIDTH +: MEM_DWIDTH];

endmodule

// File: tb/tb_layer_store.sv
// tb_layer_store: scoreboard bench for layer_store.
// Expected words are queued as vectors are offered and popped per write.

module tb_layer_store;

   localparam logic [4:0] A_ADDR = 5'd12;
   localparam logic [4:0] A_CNT  = 5'd13;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [31:0]  cfg_data = '0;
   logic [4:0]   cfg_addr = '0;
   logic         cfg_valid = 1'b0;
   logic [255:0] result_bus = '0;
   logic         result_val = 1'b0;
   logic         result_rdy;
   logic [15:0]  wr_addr;
   logic [63:0]  wr_data;
   logic         wr_val;
   logic         wr_rdy = 1'b1;
   logic         busy;
   logic         done;

   layer_store dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_data   (cfg_data),
      .cfg_addr   (cfg_addr),
      .cfg_valid  (cfg_valid),
      .result_bus (result_bus),
      .result_val (result_val),
      .result_rdy (result_rdy),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_val     (wr_val),
      .wr_rdy     (wr_rdy),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int n_writes = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int cyc      = 0;

   logic [79:0] sb[$];
   int          wr_cycles[$];
   logic [79:0] e;
   logic [15:0] exp_ptr;
   bit          rand_rdy = 1'b0;

   bit          prev_stall = 1'b0;
   logic [15:0] prev_addr;
   logic [63:0] prev_data;

   always @(negedge clk) begin
      wr_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // output monitor: pops the scoreboard on every accepted word
   always @(negedge clk) begin
      #1;
      cyc++;
      if (!rst) begin
         if (result_rdy && wr_val) begin
            n_assert++;
            n_fail++;
            $display("FAIL rdy_vs_val: result_rdy=%b wr_val=%b required not both", result_rdy, wr_val);
         end
         if (prev_stall && wr_val) begin
            n_assert++;
            if (wr_addr !== prev_addr || wr_data !== prev_data) begin
               n_fail++;
               $display("FAIL stall_hold: got %h/%h expected %h/%h", wr_addr, wr_data, prev_addr, prev_data);
            end
         end
         if (wr_val && wr_rdy) begin
            n_writes++;
            wr_cycles.push_back(cyc);
            n_assert++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: got %h/%h expected none", wr_addr, wr_data);
            end else begin
               e = sb.pop_front();
               if ({wr_addr, wr_data} !== e) begin
                  n_fail++;
                  $display("FAIL write_word: got %h/%h expected %h/%h", wr_addr, wr_data, e[79:64], e[63:0]);
               end
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_stall = wr_val && !wr_rdy;
         prev_addr  = wr_addr;
         prev_data  = wr_data;
      end else begin
         prev_stall = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [255:0] rand_vec();
      logic [255:0] v;
      for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic push_vec(input logic [255:0] v);
      for (int k = 0; k < 4; k++) begin
         sb.push_back({exp_ptr, v[k*64 +: 64]});
         exp_ptr = exp_ptr + 16'd1;
      end
   endtask

   task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      cfg_addr  = a;
      cfg_data  = d;
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic send_vec(input logic [255:0] v);
      bit ok;
      @(negedge clk);
      push_vec(v);
      result_bus = v;
      result_val = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         #2;
         if (result_rdy) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_assert++;
         n_fail++;
         $display("FAIL send_timeout: got no result_rdy expected handshake");
      end
      @(negedge clk);
      result_val = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         #2;
         if (!busy && sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_assert++;
         n_fail++;
         $display("FAIL idle_timeout: busy=%b pending=%0d expected idle", busy, sb.size());
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      #2;
      n_assert++;
      if (result_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_result_rdy: got %b expected 0", result_rdy); end
      n_assert++;
      if (wr_val !== 1'b0) begin n_fail++; $display("FAIL reset_wr_val: got %b expected 0", wr_val); end
      n_assert++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_assert++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      n_assert++;
      if (wr_addr !== 16'h0) begin n_fail++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
      n_assert++;
      if (wr_data !== 64'h0) begin n_fail++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int w0, d0;
      w0 = n_writes;
      d0 = done_cnt;
      wr_cycles.delete();
      cfg_write(A_ADDR, 32'h0100);
      exp_ptr = 16'h0100;
      cfg_write(A_CNT, 32'd2);
      #2;
      n_assert++;
      if (busy !== 1'b1 || result_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_arm: got busy=%b rdy=%b expected 1/1", busy, result_rdy);
      end
      send_vec(rand_vec());
      send_vec(rand_vec());
      wait_idle();
      n_assert++;
      if (n_writes - w0 != 8) begin n_fail++; $display("FAIL basic_count: got %0d expected 8", n_writes - w0); end
      n_assert++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d expected 1", done_cnt - d0); end
      if (wr_cycles.size() == 8) begin
         n_assert++;
         if (done_cyc != wr_cycles[7] + 1) begin
            n_fail++;
            $display("FAIL basic_done_time: got %0d expected %0d", done_cyc, wr_cycles[7] + 1);
         end
         n_assert++;
         if (wr_cycles[7] - wr_cycles[0] != 8) begin
            n_fail++;
            $display("FAIL basic_throughput: got %0d expected 8", wr_cycles[7] - wr_cycles[0]);
         end
      end
   endtask

   task automatic test_backpressure();
      int w0, d0;
      w0 = n_writes;
      d0 = done_cnt;
      rand_rdy = 1'b1;
      cfg_write(A_ADDR, 32'h0100);
      exp_ptr = 16'h0100;
      cfg_write(A_CNT, 32'd2);
      send_vec(rand_vec());
      send_vec(rand_vec());
      wait_idle();
      rand_rdy = 1'b0;
      n_assert++;
      if (n_writes - w0 != 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", n_writes - w0); end
      n_assert++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL bp_done_cnt: got %0d expected 1", done_cnt - d0); end
   endtask

   task automatic test_zero_rearm();
      int w0, d0;
      w0 = n_writes;
      cfg_write(A_CNT, 32'd0);
      repeat (4) @(negedge clk);
      #2;
      n_assert++;
      if (busy !== 1'b0 || n_writes != w0) begin
         n_fail++;
         $display("FAIL zero_count: got busy=%b writes=%0d expected 0/0", busy, n_writes - w0);
      end
      d0 = done_cnt;
      cfg_write(A_ADDR, 32'h0500);
      exp_ptr = 16'h0500;
      cfg_write(A_CNT, 32'd1);
      send_vec(rand_vec());
      cfg_write(A_CNT, 32'd5);
      wait_idle();
      n_assert++;
      if (n_writes - w0 != 4) begin n_fail++; $display("FAIL rearm_count: got %0d expected 4", n_writes - w0); end
      n_assert++;
      if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL rearm_done: got %0d expected 1", done_cnt - d0); end
      repeat (6) @(negedge clk);
      #2;
      n_assert++;
      if (busy !== 1'b0 || result_rdy !== 1'b0 || n_writes - w0 != 4) begin
         n_fail++;
         $display("FAIL rearm_idle: got busy=%b rdy=%b expected 0/0", busy, result_rdy);
      end
   endtask

   task automatic test_wrap();
      int w0;
      w0 = n_writes;
      cfg_write(A_ADDR, 32'hFFFE);
      exp_ptr = 16'hFFFE;
      cfg_write(A_CNT, 32'd1);
      send_vec(rand_vec());
      wait_idle();
      n_assert++;
      if (n_writes - w0 != 4) begin n_fail++; $display("FAIL wrap_count: got %0d expected 4", n_writes - w0); end
   endtask

   task automatic test_reset_midjob();
      int w0;
      bit ok;
      w0 = n_writes;
      cfg_write(A_ADDR, 32'h0200);
      exp_ptr = 16'h0200;
      cfg_write(A_CNT, 32'd3);
      send_vec(rand_vec());
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #2;
         if (n_writes - w0 >= 2) begin
            ok = 1'b1;
            break;
         end
      end
      n_assert++;
      if (!ok) begin n_fail++; $display("FAIL rst_mid_wait: got %0d writes expected 2", n_writes - w0); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #2;
      n_assert++;
      if ({result_rdy, wr_val, busy, done} !== 4'b0 || wr_addr !== 16'h0 || wr_data !== 64'h0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got %b%b%b%b %h %h expected all 0",
                  result_rdy, wr_val, busy, done, wr_addr, wr_data);
      end
      rst = 1'b0;
      sb.delete();
      w0 = n_writes;
      cfg_write(A_ADDR, 32'h0300);
      exp_ptr = 16'h0300;
      cfg_write(A_CNT, 32'd1);
      send_vec(rand_vec());
      wait_idle();
      n_assert++;
      if (n_writes - w0 != 4) begin n_fail++; $display("FAIL rst_rearm_count: got %0d expected 4", n_writes - w0); end
   endtask

   task automatic test_upstream_hold();
      logic [255:0] v;
      int w0;
      w0 = n_writes;
      v = rand_vec();
      @(negedge clk);
      result_bus = v;
      result_val = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      n_assert++;
      if (result_rdy !== 1'b0 || busy !== 1'b0 || n_writes != w0) begin
         n_fail++;
         $display("FAIL hold_idle: got rdy=%b busy=%b expected 0/0", result_rdy, busy);
      end
      cfg_write(A_ADDR, 32'h0400);
      exp_ptr = 16'h0400;
      push_vec(v);
      cfg_write(A_CNT, 32'd1);
      #2;
      n_assert++;
      if (result_rdy !== 1'b1) begin n_fail++; $display("FAIL hold_rdy: got %b expected 1", result_rdy); end
      @(negedge clk);
      result_val = 1'b0;
      #2;
      n_assert++;
      if (wr_val !== 1'b1 || wr_addr !== 16'h0400) begin
         n_fail++;
         $display("FAIL hold_capture: got val=%b addr=%h expected 1/0400", wr_val, wr_addr);
      end
      wait_idle();
      n_assert++;
      if (n_writes - w0 != 4) begin n_fail++; $display("FAIL hold_count: got %0d expected 4", n_writes - w0); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_rearm();
      test_wrap();
      test_reset_midjob();
      test_upstream_hold();
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
